// File: rtl/bench_stream_source_if.sv
// Valid/ready byte stream between the stream source and the profiling bench.
// The master drives data/valid and the slave returns ready.
interface bench_stream_source_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bench_stream_source.sv
// Burst generator: on start, emits `length` incrementing bytes from `seed`
// with `gap` idle cycles between beats, honouring downstream backpressure.
module bench_stream_source #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16,
    parameter int GAP_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0]  seed,
    input  logic [GAP_WIDTH-1:0]   gap,
    bench_stream_source_if.master  stream_out,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] beat_count
);

    localparam logic [DATA_WIDTH-1:0]  DATA_ONE  = 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;
    localparam logic [GAP_WIDTH-1:0]   GAP_ONE   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [DATA_WIDTH-1:0]  data_reg;
    logic                   valid_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [COUNT_WIDTH-1:0] beat_count_reg;
    logic [COUNT_WIDTH-1:0] len_reg;
    logic [GAP_WIDTH-1:0]   gap_reg;
    logic [GAP_WIDTH-1:0]   gap_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            beat_count_reg <= '0;
            len_reg        <= '0;
            gap_reg        <= '0;
            gap_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // data_reg doubles as the captured seed: it is loaded here
                    // and only ever advanced from this value.
                    if (start && (length != '0)) begin
                        len_reg        <= length;
                        gap_reg        <= gap;
                        data_reg       <= seed;
                        valid_reg      <= 1'b1;
                        busy_reg       <= 1'b1;
                        beat_count_reg <= '0;
                        state_reg      <= RUN;
                    end
                end
                RUN: begin
                    if (stream_out.ready) begin
                        beat_count_reg <= beat_count_reg + COUNT_ONE;
                        if ((beat_count_reg + COUNT_ONE) == len_reg) begin
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            data_reg <= data_reg + DATA_ONE;
                            if (gap_reg != '0) begin
                                valid_reg   <= 1'b0;
                                gap_cnt_reg <= gap_reg;
                                state_reg   <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    // Counter holds the idle cycles still to spend, including this one.
                    if (gap_cnt_reg == GAP_ONE) begin
                        valid_reg <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stream_out.data  = data_reg;
    assign stream_out.valid = valid_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign beat_count       = beat_count_reg;

endmodule
